// File: rtl/psg_bus_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : psg_bus_writer_if
// Brief    : Host write-port bundle for the PSG: write byte, active-low write
//            strobe and the READY handshake back to the host.
// Revision : 1.0 - initial release
// ============================================================================
interface psg_bus_writer_if;
    logic [7:0] data_in;   // host write byte, asynchronous to clk
    logic       we_n;      // host write strobe, active low, asynchronous
    logic       ready;     // 1 = idle and able to accept a write

    // Host side drives the byte and strobe and watches READY
    modport master (
        output data_in,
        output we_n,
        input  ready
    );

    // PSG side samples the byte and strobe and drives READY
    modport slave (
        input  data_in,
        input  we_n,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/psg_bus_writer.sv
`default_nettype none
// ============================================================================
// Module   : psg_bus_writer
// Brief    : SN76489-compatible host write port and control register file.
//            Synchronizes the asynchronous write pins, decodes latch/data
//            bytes into attenuation, tone and noise registers and models the
//            original chip's write stall with a READY handshake.
// Revision : 1.0 - initial release
// ============================================================================
module psg_bus_writer #(
    parameter int BUSY_CYCLES = 32,   // 1..255 clocks of READY low per write
    parameter int SYNC_STAGES = 2     // 2..3 synchronizer flops
) (
    input  logic                clk,
    input  logic                rst_n,
    psg_bus_writer_if.slave     bus,
    output logic [3:0]          attn0,
    output logic [3:0]          attn1,
    output logic [3:0]          attn2,
    output logic [3:0]          attn3,
    output logic [9:0]          tone0,
    output logic [9:0]          tone1,
    output logic [9:0]          tone2,
    output logic [2:0]          noise_ctrl,
    output logic                noise_reset
);

    localparam logic [7:0] c_busy_load = 8'(BUSY_CYCLES);

    // Synchronizer chains and previous synchronized strobe for edge detection
    logic [SYNC_STAGES-1:0] r_we_sync;
    logic [7:0]             r_data_sync [SYNC_STAGES];
    logic                   r_we_prev;

    // Latched target: channel and volume/tone select
    logic [1:0]             r_tgt_ch;
    logic                   r_tgt_vol;

    // Control register file
    logic [3:0]             r_attn [4];
    logic [9:0]             r_tone [3];
    logic [2:0]             r_noise_ctrl;
    logic                   r_noise_reset;

    // Write-stall counter; READY is high exactly when it is zero
    logic [7:0]             r_busy_cnt;

    logic                   w_we_s;
    logic [7:0]             w_byte;
    logic                   w_ready;
    logic                   w_write;
    logic                   w_is_latch;
    logic [1:0]             w_ch;
    logic                   w_vol;

    assign w_we_s     = r_we_sync[SYNC_STAGES-1];
    assign w_byte     = r_data_sync[SYNC_STAGES-1];
    assign w_ready    = (r_busy_cnt == 8'd0);
    // Falling edge of the synchronized strobe, honoured only while idle
    assign w_write    = r_we_prev & ~w_we_s & w_ready;
    assign w_is_latch = w_byte[7];
    // A latch byte retargets before its low nibble is written
    assign w_ch       = w_is_latch ? w_byte[6:5] : r_tgt_ch;
    assign w_vol      = w_is_latch ? w_byte[4]   : r_tgt_vol;

    // Bring the asynchronous strobe and byte into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we_sync <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_data_sync[i] <= 8'h00;
            end
            r_we_prev <= 1'b1;
        end else begin
            r_we_sync      <= {r_we_sync[SYNC_STAGES-2:0], bus.we_n};
            r_data_sync[0] <= bus.data_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_data_sync[i] <= r_data_sync[i-1];
            end
            r_we_prev <= w_we_s;
        end
    end

    // Load the stall counter on an accepted write and count it down to idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_cnt <= 8'd0;
        end else if (w_write) begin
            r_busy_cnt <= c_busy_load;
        end else if (!w_ready) begin
            r_busy_cnt <= r_busy_cnt - 8'd1;
        end
    end

    // Decode an accepted byte into the latched target and register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tgt_ch      <= 2'd0;
            r_tgt_vol     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_attn[i] <= 4'hF;
            end
            for (int i = 0; i < 3; i++) begin
                r_tone[i] <= 10'd0;
            end
            r_noise_ctrl  <= 3'd0;
            r_noise_reset <= 1'b0;
        end else begin
            r_noise_reset <= 1'b0;
            if (w_write) begin
                if (w_is_latch) begin
                    r_tgt_ch  <= w_ch;
                    r_tgt_vol <= w_vol;
                end
                if (w_vol) begin
                    for (int i = 0; i < 4; i++) begin
                        if (w_ch == 2'(i)) begin
                            r_attn[i] <= w_byte[3:0];
                        end
                    end
                end else if (w_ch == 2'd3) begin
                    // Any noise-control write reseeds the noise LFSR
                    r_noise_ctrl  <= w_byte[2:0];
                    r_noise_reset <= 1'b1;
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        if (w_ch == 2'(i)) begin
                            if (w_is_latch) begin
                                r_tone[i][3:0] <= w_byte[3:0];
                            end else begin
                                r_tone[i][9:4] <= w_byte[5:0];
                            end
                        end
                    end
                end
            end
        end
    end

    assign bus.ready   = w_ready;
    assign attn0       = r_attn[0];
    assign attn1       = r_attn[1];
    assign attn2       = r_attn[2];
    assign attn3       = r_attn[3];
    assign tone0       = r_tone[0];
    assign tone1       = r_tone[1];
    assign tone2       = r_tone[2];
    assign noise_ctrl  = r_noise_ctrl;
    assign noise_reset = r_noise_reset;

endmodule
`default_nettype wire

// File: tb/tb_psg_bus_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_psg_bus_writer
// Brief    : Self-checking bench for psg_bus_writer: directed vector table,
//            hand-written busy/reset sequences and random writes against a
//            behavioural model of the SN76489 register protocol.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psg_bus_writer;

    localparam int BUSY = 32;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] attn0, attn1, attn2, attn3;
    logic [9:0] tone0, tone1, tone2;
    logic [2:0] noise_ctrl;
    logic       noise_reset;

    always #5 clk = ~clk;

    psg_bus_writer_if bus ();

    psg_bus_writer #(.BUSY_CYCLES(BUSY), .SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .attn0       (attn0),
        .attn1       (attn1),
        .attn2       (attn2),
        .attn3       (attn3),
        .tone0       (tone0),
        .tone1       (tone1),
        .tone2       (tone2),
        .noise_ctrl  (noise_ctrl),
        .noise_reset (noise_reset)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    logic [3:0] m_attn [4];
    logic [9:0] m_tone [3];
    logic [2:0] m_noise;
    int         m_ch;
    bit         m_vol;
    int         m_last;

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) m_attn[i] = 4'hF;
        for (int i = 0; i < 3; i++) m_tone[i] = 10'd0;
        m_noise = 3'd0;
        m_ch    = 0;
        m_vol   = 1'b0;
        m_last  = -1000;
    endfunction

    // ready as seen just after clock edge number c
    function automatic bit m_ready(input int c);
        return (c - m_last) >= BUSY;
    endfunction

    // returns 1 when the write reaches the noise control register
    function automatic bit m_apply(input logic [7:0] b);
        int val;
        val = int'(b);
        if (val >= 128) begin
            m_ch  = (val / 32) % 4;
            m_vol = ((val / 16) % 2) == 1;
        end
        if (m_vol) begin
            m_attn[m_ch] = 4'(val % 16);
            return 1'b0;
        end
        if (m_ch == 3) begin
            m_noise = 3'(val % 8);
            return 1'b1;
        end
        if (val >= 128)
            m_tone[m_ch] = 10'((int'(m_tone[m_ch]) / 16) * 16 + val % 16);
        else
            m_tone[m_ch] = 10'((val % 64) * 16 + int'(m_tone[m_ch]) % 16);
        return 1'b0;
    endfunction

    function automatic logic [48:0] m_snap();
        return {m_attn[0], m_attn[1], m_attn[2], m_attn[3],
                m_tone[0], m_tone[1], m_tone[2], m_noise};
    endfunction

    function automatic logic [48:0] d_snap();
        return {attn0, attn1, attn2, attn3, tone0, tone1, tone2, noise_ctrl};
    endfunction

    function automatic logic [9:0] sel_out(input int sel);
        case (sel)
            0: return {6'd0, attn0};
            1: return {6'd0, attn1};
            2: return {6'd0, attn2};
            3: return {6'd0, attn3};
            4: return tone0;
            5: return tone1;
            6: return tone2;
            default: return {7'd0, noise_ctrl};
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one byte with we_n low for h clocks; checks every cycle it spans.
    task automatic do_write(input logic [7:0] b, input int h, output bit acc, output logic nr_seen);
        int  p3;
        int  kmax;
        bit  exp_nr;
        @(negedge clk);
        bus.data_in = b;
        bus.we_n    = 1'b0;
        p3     = cyc + 3;
        acc    = m_ready(p3 - 1);
        exp_nr = 1'b0;
        nr_seen = 1'b0;
        kmax   = (h > 3) ? h : 3;
        for (int k = 1; k <= kmax; k++) begin
            @(posedge clk);
            #1;
            if (k == 3 && acc) begin
                exp_nr = m_apply(b);
                m_last = p3;
            end
            check("regs", d_snap(), m_snap());
            check("ready", bus.ready, m_ready(cyc));
            check("noise_reset", noise_reset, (k == 3) ? exp_nr : 1'b0);
            if (k == 3) nr_seen = noise_reset;
            @(negedge clk);
            if (k == h) bus.we_n = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("idle_regs", d_snap(), m_snap());
            check("idle_ready", bus.ready, m_ready(cyc));
            check("idle_noise_reset", noise_reset, 1'b0);
            @(negedge clk);
        end
    endtask

    // Count clocks READY stays low, starting right after the accepting edge
    task automatic busy_len(output int len);
        len = 1;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            #1;
            if (bus.ready) break;
            len++;
        end
    endtask

    typedef struct {
        logic [7:0] b;
        int         sel;
        logic [9:0] exp;
        logic       exp_nr;
    } vec_t;

    vec_t tbl [12];
    bit   acc;
    logic nr;
    int   len;
    int   e;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{8'h8E, 4, 10'h00E, 1'b0};
        tbl[1]  = '{8'h0F, 4, 10'h0FE, 1'b0};
        tbl[2]  = '{8'hB5, 1, 10'h005, 1'b0};
        tbl[3]  = '{8'h09, 1, 10'h009, 1'b0};
        tbl[4]  = '{8'hE6, 7, 10'h006, 1'b1};
        tbl[5]  = '{8'hF3, 3, 10'h003, 1'b0};
        tbl[6]  = '{8'hC1, 6, 10'h001, 1'b0};
        tbl[7]  = '{8'h9A, 0, 10'h00A, 1'b0};
        tbl[8]  = '{8'hA7, 5, 10'h007, 1'b0};
        tbl[9]  = '{8'h7F, 5, 10'h3F7, 1'b0};
        tbl[10] = '{8'hEB, 7, 10'h003, 1'b1};
        tbl[11] = '{8'h05, 7, 10'h005, 1'b1};

        bus.we_n    = 1'b1;
        bus.data_in = 8'h00;
        rst_n       = 1'b0;
        m_reset();

        // reset state
        repeat (3) @(negedge clk);
        check("reset_ready", bus.ready, 1'b1);
        check("reset_regs", d_snap(), {16'hFFFF, 33'd0});
        check("reset_noise_reset", noise_reset, 1'b0);
        rst_n = 1'b1;
        idle(2);

        // directed vector table
        for (int i = 0; i < 12; i++) begin
            do_write(tbl[i].b, 3, acc, nr);
            check($sformatf("tbl%0d_value", i), sel_out(tbl[i].sel), tbl[i].exp);
            check($sformatf("tbl%0d_noise_reset", i), nr, tbl[i].exp_nr);
            busy_len(len);
            check($sformatf("tbl%0d_busy_len", i), len, BUSY);
        end
        check("tbl_tone0_kept", tone0, 10'h0FE);

        // write dropped while busy does not extend the window
        do_write(8'hC3, 2, acc, nr);
        e = m_last;
        idle(6);
        do_write(8'h3F, 2, acc, nr);
        check("drop_tone2", tone2, 10'h003);
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            #1;
            if (bus.ready) break;
        end
        check("drop_window_end", cyc, e + BUSY);
        idle(2);

        // strobe held low across the whole busy window yields one event
        do_write(8'hD2, 45, acc, nr);
        check("hold_attn2", attn2, 4'h2);
        idle(40);

        // reset in the middle of a busy window
        do_write(8'h84, 3, acc, nr);
        idle(5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", bus.ready, 1'b1);
        check("midrst_regs", d_snap(), {16'hFFFF, 33'd0});
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_write(8'h15, 3, acc, nr);
        check("postrst_tone0", tone0, 10'h150);
        busy_len(len);
        do_write(8'h9A, 3, acc, nr);
        check("postrst_attn0", attn0, 4'hA);
        busy_len(len);

        // random writes, some landing inside busy windows
        for (int i = 0; i < 80; i++) begin
            do_write(8'($urandom), int'($urandom_range(1, 6)), acc, nr);
            idle(int'($urandom_range(0, 38)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
